// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared states, opcodes and datapath select codes for the multicycle controller
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // funct3 values the ALU decoder actually implements (add/sub, slt, or, and)
    function automatic logic funct3_alu_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - ALU decoder: ALUOp plus instruction fields to ALUControl
import mc_ctrl_pkg::*;

module mc_aludec (
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // only R-type (op5=1) can subtract; addi ignores imm bit 30
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle RV32I-subset control FSM with memory-ready stalls
import mc_ctrl_pkg::*;

module mc_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               RegWrite,
    output logic [1:0]         ImmSrc,
    output logic [2:0]         ALUControl,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    state_t     state, state_next;
    logic       pcupdate, branch;
    logic       irwrite_s, memwrite_s, regwrite_s, illegal_s;
    logic [1:0] aluop;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        illegal_s  = 1'b0;
        aluop      = ALUOP_ADD;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                irwrite_s = MemReady;
                pcupdate  = MemReady;
                if (MemReady) state_next = S_DECODE;
            end
            S_DECODE: begin
                // precompute branch/jal target into ALUOut while decoding
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:   state_next = (funct3_alu_ok(funct3) && (!funct7b5 || funct3 == 3'b000))
                                         ? S_EXECR : S_TRAP;
                    OP_I:   state_next = funct3_alu_ok(funct3) ? S_EXECI : S_TRAP;
                    OP_JAL: state_next = S_JAL;
                    OP_BEQ: state_next = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
                    default: state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                regwrite_s = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                memwrite_s = 1'b1;
                if (MemReady) state_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RD1;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
                state_next = S_FETCH;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pcupdate   = 1'b1;
                state_next = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RD1;
                aluop      = ALUOP_SUB;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                illegal_s = 1'b1;
            end
            default: state_next = S_TRAP;
        endcase
    end

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alucontrol (ALUControl)
    );

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    // enables are gated by reset so an abandoned instruction cannot write anything
    assign PCWrite  = reset & (pcupdate | (branch & Zero));
    assign IRWrite  = reset & irwrite_s;
    assign MemWrite = reset & memwrite_s;
    assign RegWrite = reset & regwrite_s;
    assign Illegal  = reset & illegal_s;
    assign State    = STATE_W'(state);

endmodule
